nn_dense_layer: RTL and testbench

- Fully connected neural-network layer in signed fixed point (Q INT_W.FRAC_W).
- Forward pass computes output_f = W·inputs_f + b.
- Backward pass computes output_b = Wᵀ·inputs_b and applies an SGD weight/bias update in place.
- Weights live in an external RAM; products come from an external combinational multiplier. Layers chain through the start/ready handshake.

---
 rtl/nn_dense_layer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_nn_dense_layer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_dense_layer.sv
// nn_dense_layer: signed fixed-point fully connected layer with a forward MAC pass and a
// backward pass (error propagation plus in-place SGD update). Define LAYER_SAT_EN for saturating arithmetic.
module nn_dense_layer #(
  parameter int INT_W          = 8,
  parameter int FRAC_W         = 8,
  parameter int INPUTS         = 3,
  parameter int OUTPUTS        = 2,
  parameter int RAM_ADDR_W     = 8,
  parameter int RAM_ADDR_START = 0,
  parameter int RAM_DELAY      = 1,
  localparam int NUM_W         = INT_W + FRAC_W
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       enable,
  input  logic [NUM_W*INPUTS-1:0]    inputs_f,
  input  logic [NUM_W*OUTPUTS-1:0]   inputs_b,
  output logic [NUM_W*OUTPUTS-1:0]   output_f,
  output logic [NUM_W*INPUTS-1:0]    output_b,
  output logic                       mult_en,
  output logic [NUM_W-1:0]           mult_v1,
  output logic [NUM_W-1:0]           mult_v2,
  input  logic [NUM_W-1:0]           mult_res,
  output logic                       ram_write,
  output logic [RAM_ADDR_W-1:0]      ram_addr_write,
  output logic [NUM_W-1:0]           ram_data_write,
  output logic [RAM_ADDR_W-1:0]      ram_addr_read,
  input  logic [NUM_W-1:0]           ram_data_read,
  input  logic                       ready_f_in,
  input  logic                       ready_b_in,
  output logic                       ready_out,
  input  logic                       start_f,
  input  logic                       start_b
);

  localparam int IN_IDX_W  = $clog2(INPUTS + 1);
  localparam int OUT_IDX_W = $clog2(OUTPUTS + 1);
  localparam int WAIT_W    = $clog2(RAM_DELAY + 1);
  localparam logic [RAM_ADDR_W-1:0] ADDR_START = RAM_ADDR_W'(RAM_ADDR_START);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F_ADDR = 3'd1,
    S_F_WAIT = 3'd2,
    S_F_ACC  = 3'd3,
    S_B_ADDR = 3'd4,
    S_B_WAIT = 3'd5,
    S_B_DOT  = 3'd6,
    S_B_UPD  = 3'd7
  } state_t;

`ifdef LAYER_SAT_EN
  localparam logic [NUM_W-1:0] Q_MAX = {1'b0, {(NUM_W-1){1'b1}}};
  localparam logic [NUM_W-1:0] Q_MIN = {1'b1, {(NUM_W-1){1'b0}}};

  function automatic logic [NUM_W-1:0] sat_q(input logic [NUM_W:0] s);
    if (s[NUM_W] != s[NUM_W-1]) begin
      return s[NUM_W] ? Q_MIN : Q_MAX;
    end else begin
      return s[NUM_W-1:0];
    end
  endfunction
`endif

  function automatic logic [NUM_W-1:0] add_q(input logic [NUM_W-1:0] a, input logic [NUM_W-1:0] b);
`ifdef LAYER_SAT_EN
    return sat_q({a[NUM_W-1], a} + {b[NUM_W-1], b});
`else
    return a + b;
`endif
  endfunction

  function automatic logic [NUM_W-1:0] sub_q(input logic [NUM_W-1:0] a, input logic [NUM_W-1:0] b);
`ifdef LAYER_SAT_EN
    return sat_q({a[NUM_W-1], a} - {b[NUM_W-1], b});
`else
    return a - b;
`endif
  endfunction

  state_t                 state_r, state_s;
  logic [WAIT_W-1:0]      wait_cnt_r;
  logic [IN_IDX_W-1:0]    in_idx_r, in_idx_nx_s;
  logic [OUT_IDX_W-1:0]   out_idx_r, out_idx_nx_s;
  logic [RAM_ADDR_W-1:0]  addr_r;
  logic [NUM_W-1:0]       x_r         [INPUTS];
  logic [NUM_W-1:0]       delta_r     [OUTPUTS];
  logic [NUM_W-1:0]       results_f_r [OUTPUTS];
  logic [NUM_W-1:0]       results_b_r [INPUTS];
  logic [NUM_W-1:0]       w_old_r;
  logic                   ready_r;
  logic                   start_f_s, start_b_s, is_bias_s, last_word_s, wait_done_s;
  logic [NUM_W-1:0]       x_sel_s, delta_sel_s;
  logic                   mult_en_s, ram_write_s;
  logic [NUM_W-1:0]       mult_v1_s, mult_v2_s, ram_data_write_s;

  // Start qualification, word position decode and operand selection.
  always_comb begin
    start_f_s    = enable & ready_r & (state_r == S_IDLE) & start_f & ready_f_in;
    start_b_s    = enable & ready_r & (state_r == S_IDLE) & start_b & ready_b_in & ~start_f_s;
    is_bias_s    = (in_idx_r == IN_IDX_W'(INPUTS));
    last_word_s  = is_bias_s & (out_idx_r == OUT_IDX_W'(OUTPUTS - 1));
    wait_done_s  = (wait_cnt_r == WAIT_W'(RAM_DELAY - 2));
    in_idx_nx_s  = is_bias_s ? '0 : in_idx_r + IN_IDX_W'(1);
    out_idx_nx_s = is_bias_s ? out_idx_r + OUT_IDX_W'(1) : out_idx_r;
    x_sel_s      = '0;
    delta_sel_s  = '0;
    for (int k = 0; k < INPUTS; k++) begin
      x_sel_s = (in_idx_r == IN_IDX_W'(k)) ? x_r[k] : x_sel_s;
    end
    for (int k = 0; k < OUTPUTS; k++) begin
      delta_sel_s = (out_idx_r == OUT_IDX_W'(k)) ? delta_r[k] : delta_sel_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; a low enable freezes the sequence.
  always_comb begin
    state_s = state_r;
    if (enable) begin
      case (state_r)
        S_IDLE: begin
          if (start_f_s) begin
            state_s = S_F_ADDR;
          end else if (start_b_s) begin
            state_s = S_B_ADDR;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_F_ADDR: state_s = (RAM_DELAY > 1) ? S_F_WAIT : S_F_ACC;
        S_F_WAIT: state_s = wait_done_s ? S_F_ACC : S_F_WAIT;
        S_F_ACC:  state_s = last_word_s ? S_IDLE : S_F_ADDR;
        S_B_ADDR: state_s = (RAM_DELAY > 1) ? S_B_WAIT : S_B_DOT;
        S_B_WAIT: state_s = wait_done_s ? S_B_DOT : S_B_WAIT;
        S_B_DOT:  state_s = S_B_UPD;
        S_B_UPD:  state_s = last_word_s ? S_IDLE : S_B_ADDR;
        default:  state_s = S_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM outputs: multiplier operands and the write-back word.
  always_comb begin
    mult_en_s        = 1'b0;
    mult_v1_s        = '0;
    mult_v2_s        = '0;
    ram_write_s      = 1'b0;
    ram_data_write_s = '0;
    case (state_r)
      S_F_ACC: begin
        mult_en_s = ~is_bias_s;
        mult_v1_s = ram_data_read;
        mult_v2_s = x_sel_s;
      end
      S_B_DOT: begin
        mult_en_s = ~is_bias_s;
        mult_v1_s = ram_data_read;
        mult_v2_s = delta_sel_s;
      end
      S_B_UPD: begin
        mult_en_s        = ~is_bias_s;
        mult_v1_s        = delta_sel_s;
        mult_v2_s        = x_sel_s;
        ram_write_s      = 1'b1;
        ram_data_write_s = is_bias_s ? sub_q(w_old_r, delta_sel_s) : sub_q(w_old_r, mult_res);
      end
      default: begin
        mult_en_s   = 1'b0;
        ram_write_s = 1'b0;
      end
    endcase
  end

  // Datapath: input latches, word counters, accumulators and the ready flag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < INPUTS; k++) begin
        x_r[k]         <= '0;
        results_b_r[k] <= '0;
      end
      for (int k = 0; k < OUTPUTS; k++) begin
        delta_r[k]     <= '0;
        results_f_r[k] <= '0;
      end
      w_old_r    <= '0;
      addr_r     <= ADDR_START;
      in_idx_r   <= '0;
      out_idx_r  <= '0;
      wait_cnt_r <= '0;
      ready_r    <= 1'b1;
    end else if (enable) begin
      case (state_r)
        S_IDLE: begin
          if (start_f_s) begin
            for (int k = 0; k < INPUTS; k++) begin
              x_r[k] <= inputs_f[k*NUM_W +: NUM_W];
            end
            for (int k = 0; k < OUTPUTS; k++) begin
              results_f_r[k] <= '0;
            end
          end else if (start_b_s) begin
            for (int k = 0; k < OUTPUTS; k++) begin
              delta_r[k] <= inputs_b[k*NUM_W +: NUM_W];
            end
            for (int k = 0; k < INPUTS; k++) begin
              results_b_r[k] <= '0;
            end
          end
          if (start_f_s | start_b_s) begin
            addr_r     <= ADDR_START;
            in_idx_r   <= '0;
            out_idx_r  <= '0;
            wait_cnt_r <= '0;
            ready_r    <= 1'b0;
          end
        end
        S_F_WAIT, S_B_WAIT: begin
          wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end
        S_F_ACC: begin
          // The bias word bypasses the multiplier and is added as read.
          for (int k = 0; k < OUTPUTS; k++) begin
            if (out_idx_r == OUT_IDX_W'(k)) begin
              results_f_r[k] <= add_q(results_f_r[k], is_bias_s ? ram_data_read : mult_res);
            end
          end
          in_idx_r   <= in_idx_nx_s;
          out_idx_r  <= out_idx_nx_s;
          addr_r     <= addr_r + RAM_ADDR_W'(1);
          wait_cnt_r <= '0;
          ready_r    <= last_word_s;
        end
        S_B_DOT: begin
          w_old_r <= ram_data_read;
          for (int k = 0; k < INPUTS; k++) begin
            if (!is_bias_s && (in_idx_r == IN_IDX_W'(k))) begin
              results_b_r[k] <= add_q(results_b_r[k], mult_res);
            end
          end
        end
        S_B_UPD: begin
          in_idx_r   <= in_idx_nx_s;
          out_idx_r  <= out_idx_nx_s;
          addr_r     <= addr_r + RAM_ADDR_W'(1);
          wait_cnt_r <= '0;
          ready_r    <= last_word_s;
        end
        default: begin
          ready_r <= ready_r;
        end
      endcase
    end
  end

  for (genvar g = 0; g < OUTPUTS; g++) begin : g_out_f
    assign output_f[g*NUM_W +: NUM_W] = results_f_r[g];
  end
  for (genvar g = 0; g < INPUTS; g++) begin : g_out_b
    assign output_b[g*NUM_W +: NUM_W] = results_b_r[g];
  end

  assign mult_en        = mult_en_s & enable;
  assign mult_v1        = mult_v1_s;
  assign mult_v2        = mult_v2_s;
  assign ram_write      = ram_write_s & enable;
  assign ram_addr_write = addr_r;
  assign ram_data_write = ram_data_write_s;
  assign ram_addr_read  = addr_r;
  assign ready_out      = ready_r;

endmodule

// File: tb/tb_nn_dense_layer.sv
// tb_nn_dense_layer: directed plus randomized checks of nn_dense_layer against an
// arithmetic reference model, with a behavioural RAM and multiplier.
module tb_nn_dense_layer;

  localparam int NI = 3;
  localparam int NO = 2;
  localparam int NW = (NI + 1) * NO;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        enable = 1'b0;
  logic [47:0] inputs_f = '0;
  logic [31:0] inputs_b = '0;
  logic [31:0] output_f;
  logic [47:0] output_b;
  logic        mult_en;
  logic [15:0] mult_v1, mult_v2, mult_res;
  logic        ram_write;
  logic [7:0]  ram_addr_write, ram_addr_read;
  logic [15:0] ram_data_write;
  logic [15:0] ram_data_read = '0;
  logic        ready_f_in = 1'b0, ready_b_in = 1'b0, start_f = 1'b0, start_b = 1'b0;
  logic        ready_out;

  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [15:0] mem [0:255];
  int          wr_cnt = 0, mul_cnt = 0;

  logic signed [31:0] prod_s, prod_sh_s;
  logic [15:0] mw [NW];
  logic [15:0] mx [NI];
  logic [15:0] md [NO];
  logic [15:0] ef [NO];
  logic [15:0] eb [NI];
  int          n_pass = 0, n_total = 0;
  int          lat, w0, m0;

  always #5 clk = ~clk;

  nn_dense_layer dut (
    .clk(clk), .nreset(nreset), .enable(enable),
    .inputs_f(inputs_f), .inputs_b(inputs_b), .output_f(output_f), .output_b(output_b),
    .mult_en(mult_en), .mult_v1(mult_v1), .mult_v2(mult_v2), .mult_res(mult_res),
    .ram_write(ram_write), .ram_addr_write(ram_addr_write), .ram_data_write(ram_data_write),
    .ram_addr_read(ram_addr_read), .ram_data_read(ram_data_read),
    .ready_f_in(ready_f_in), .ready_b_in(ready_b_in), .ready_out(ready_out),
    .start_f(start_f), .start_b(start_b)
  );

  assign prod_s    = $signed(mult_v1) * $signed(mult_v2);
  assign prod_sh_s = prod_s >>> 8;
  assign mult_res  = prod_sh_s[15:0];

  always @(posedge clk) begin
    ram_data_read <= mem[ram_addr_read];
    if (ram_write) mem[ram_addr_write] <= ram_data_write;
    else if (pre_we) mem[pre_addr] <= pre_data;
    if (ram_write) wr_cnt <= wr_cnt + 1;
    if (mult_en) mul_cnt <= mul_cnt + 1;
  end

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 8;
    return p[15:0];
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef LAYER_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  function automatic logic [15:0] m_sub(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) - int'($signed(b));
`ifdef LAYER_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_all();
    for (int a = 0; a < NW; a++) begin
      pre_we = 1'b1; pre_addr = 8'(a); pre_data = mw[a];
      step();
    end
    pre_we = 1'b0;
  endtask

  task automatic model_fwd();
    logic [15:0] acc;
    for (int i = 0; i < NO; i++) begin
      acc = 16'h0000;
      for (int j = 0; j < NI; j++) acc = m_add(acc, m_mul(mw[i*(NI+1)+j], mx[j]));
      ef[i] = m_add(acc, mw[i*(NI+1)+NI]);
    end
  endtask

  task automatic model_bwd();
    for (int j = 0; j < NI; j++) eb[j] = 16'h0000;
    for (int i = 0; i < NO; i++)
      for (int j = 0; j < NI; j++) eb[j] = m_add(eb[j], m_mul(mw[i*(NI+1)+j], md[i]));
    for (int i = 0; i < NO; i++) begin
      for (int j = 0; j < NI; j++) mw[i*(NI+1)+j] = m_sub(mw[i*(NI+1)+j], m_mul(md[i], mx[j]));
      mw[i*(NI+1)+NI] = m_sub(mw[i*(NI+1)+NI], md[i]);
    end
  endtask

  task automatic check_fwd(input string tag);
    for (int i = 0; i < NO; i++) chk($sformatf("%s_out_f%0d", tag, i), output_f[i*16 +: 16], ef[i]);
  endtask

  task automatic check_bwd(input string tag);
    for (int j = 0; j < NI; j++) chk($sformatf("%s_out_b%0d", tag, j), output_b[j*16 +: 16], eb[j]);
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < NW; a++) chk($sformatf("%s_ram%0d", tag, a), mem[a], mw[a]);
  endtask

  // mode 0 forward, 1 backward, 2 both starts together; optional enable gap and busy-start noise
  task automatic run_pass(input int mode, input int gap_at, input int gap_len, input bit noise, output int cycles);
    for (int j = 0; j < NI; j++) inputs_f[j*16 +: 16] = mx[j];
    for (int i = 0; i < NO; i++) inputs_b[i*16 +: 16] = md[i];
    start_f = (mode != 1); ready_f_in = (mode != 1);
    start_b = (mode != 0); ready_b_in = (mode != 0);
    step();
    start_f = 1'b0; start_b = 1'b0;
    cycles = 0;
    while (cycles < 200) begin
      if (gap_len > 0 && cycles == gap_at) enable = 1'b0;
      if (gap_len > 0 && cycles == gap_at + gap_len) enable = 1'b1;
      if (noise && cycles == 3) begin
        inputs_f = 48'(~inputs_f); inputs_b = 32'(~inputs_b);
        start_f = 1'b1; ready_f_in = 1'b1; start_b = 1'b1; ready_b_in = 1'b1;
      end
      if (noise && cycles == 5) begin start_f = 1'b0; start_b = 1'b0; end
      if (!enable) begin
        #1;
        chk("gap_mult_en", mult_en, 1'b0);
        chk("gap_ram_write", ram_write, 1'b0);
      end
      step();
      cycles++;
      if (ready_out) break;
    end
    enable = 1'b1;
  endtask

  initial begin
    step(); step();
    chk("rst_output_f", output_f, 32'h0);
    chk("rst_output_b", output_b, 48'h0);
    chk("rst_ready_out", ready_out, 1'b1);
    chk("rst_ram_write", ram_write, 1'b0);
    chk("rst_mult_en", mult_en, 1'b0);
    chk("rst_addr_read", ram_addr_read, 8'h00);
    chk("rst_addr_write", ram_addr_write, 8'h00);
    nreset = 1'b1; enable = 1'b1;
    step();

    // reference forward and backward vectors
    mw = '{16'h0000, 16'h0080, 16'hFF00, 16'h0180, 16'hFE00, 16'h0280, 16'hFD00, 16'h0380};
    preload_all();
    mx = '{16'h0080, 16'h0180, 16'h0280};
    run_pass(0, 0, 0, 1'b0, lat);
    chk("ref_fwd_latency", lat, 16);
    chk("ref_fwd_out0", output_f[15:0], 16'hFFC0);
    chk("ref_fwd_out1", output_f[31:16], 16'hFEC0);
    model_fwd();
    check_fwd("ref_fwd");
    md = '{16'h0100, 16'h0080};
    run_pass(1, 0, 0, 1'b0, lat);
    chk("ref_bwd_latency", lat, 24);
    chk("ref_bwd_out0", output_b[15:0], 16'hFF00);
    chk("ref_bwd_out1", output_b[31:16], 16'h01C0);
    chk("ref_bwd_out2", output_b[47:32], 16'hFD80);
    chk("ref_bwd_ram0", mem[0], 16'hFF80);
    chk("ref_bwd_ram1", mem[1], 16'hFF00);
    chk("ref_bwd_ram2", mem[2], 16'hFC80);
    chk("ref_bwd_ram3", mem[3], 16'h0080);
    model_bwd();
    check_ram("ref_bwd");
    check_bwd("ref_bwd");

    // starts without upstream/downstream valid are ignored
    w0 = wr_cnt; m0 = mul_cnt;
    inputs_f = 48'h0123_4567_89AB; start_f = 1'b1; ready_f_in = 1'b0;
    inputs_b = 32'h1111_2222; start_b = 1'b1; ready_b_in = 1'b0;
    step(); step();
    start_f = 1'b0; start_b = 1'b0;
    step();
    chk("nostart_ready", ready_out, 1'b1);
    chk("nostart_writes", wr_cnt, w0);
    chk("nostart_mults", mul_cnt, m0);
    check_fwd("nostart");
    check_bwd("nostart");

    // starts while busy are ignored
    mx = '{16'h0100, 16'hFF80, 16'h0040};
    run_pass(0, 0, 0, 1'b1, lat);
    chk("busy_latency", lat, 16);
    model_fwd();
    check_fwd("busy");

    // simultaneous starts: forward only, no RAM writes
    w0 = wr_cnt;
    mx = '{16'h0200, 16'h0010, 16'hFFF0};
    md = '{16'h0F00, 16'h0E00};
    run_pass(2, 0, 0, 1'b0, lat);
    chk("both_latency", lat, 16);
    chk("both_writes", wr_cnt, w0);
    model_fwd();
    check_fwd("both");
    check_bwd("both");

    // floored product of -1 x 1 LSB
    mw = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    preload_all();
    mx = '{16'hFF00, 16'h0000, 16'h0000};
    run_pass(0, 0, 0, 1'b0, lat);
    chk("floor_out0", output_f[15:0], 16'hFFFF);
    model_fwd();
    check_fwd("floor");

    // overflow of the accumulator
    mw = '{16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    preload_all();
    mx = '{16'h0100, 16'h0100, 16'h0000};
    run_pass(0, 0, 0, 1'b0, lat);
`ifdef LAYER_SAT_EN
    chk("ovf_out0", output_f[15:0], 16'h7FFF);
`else
    chk("ovf_out0", output_f[15:0], 16'hFE00);
`endif
    model_fwd();
    check_fwd("ovf");

    // enable gaps stretch both passes by exactly their length
    for (int a = 0; a < NW; a++) mw[a] = 16'($urandom_range(0, 16'h03FF)) - 16'h0200;
    preload_all();
    for (int j = 0; j < NI; j++) mx[j] = 16'($urandom);
    run_pass(0, 3, 5, 1'b0, lat);
    chk("gap_fwd_latency", lat, 21);
    model_fwd();
    check_fwd("gap_fwd");
    for (int i = 0; i < NO; i++) md[i] = 16'($urandom);
    run_pass(1, 4, 5, 1'b0, lat);
    chk("gap_bwd_latency", lat, 29);
    model_bwd();
    check_bwd("gap_bwd");
    check_ram("gap_bwd");

    // reset in the middle of a forward pass
    for (int j = 0; j < NI; j++) inputs_f[j*16 +: 16] = 16'h0100;
    start_f = 1'b1; ready_f_in = 1'b1;
    step();
    start_f = 1'b0;
    repeat (7) step();
    nreset = 1'b0;
    #1;
    chk("midrst_output_f", output_f, 32'h0);
    chk("midrst_output_b", output_b, 48'h0);
    chk("midrst_ready", ready_out, 1'b1);
    chk("midrst_addr", ram_addr_read, 8'h00);
    step();
    nreset = 1'b1;
    step();
    for (int j = 0; j < NI; j++) mx[j] = 16'h0000;
    for (int i = 0; i < NO; i++) md[i] = 16'h0000;
    check_ram("midrst");

    // randomized forward/backward rounds
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < NW; a++) mw[a] = 16'($urandom);
      preload_all();
      for (int j = 0; j < NI; j++) mx[j] = 16'($urandom);
      run_pass(0, 0, 0, 1'b0, lat);
      chk($sformatf("rnd%0d_fwd_latency", r), lat, 16);
      model_fwd();
      check_fwd($sformatf("rnd%0d", r));
      for (int i = 0; i < NO; i++) md[i] = 16'($urandom);
      run_pass(1, 0, 0, 1'b0, lat);
      chk($sformatf("rnd%0d_bwd_latency", r), lat, 24);
      model_bwd();
      check_bwd($sformatf("rnd%0d", r));
      check_ram($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
